// File: rtl/eeprom_req_arb_pkg.sv
// Shared definitions for the EEPROM request arbiter: FSM encoding, default timing
// parameters and a counter-width helper.
package eeprom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_RESP
  } state_t;

  localparam int DEF_WR_CYCLE  = 10000;
  localparam int DEF_RETRY_GAP = 1000;
  localparam int DEF_MAX_RETRY = 3;

  localparam logic [6:0] SLAVE_ADDR = 7'b1010000;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eeprom_req_arb_if.sv
// Requester handshakes plus the i2c_dri command/response bus, grouped for the arbiter.
interface eeprom_req_arb_if;

  logic        req_a;
  logic        rh_wl_a;
  logic [15:0] addr_a;
  logic [7:0]  wdata_a;
  logic        done_a;
  logic        req_b;
  logic        rh_wl_b;
  logic [15:0] addr_b;
  logic [7:0]  wdata_b;
  logic        done_b;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic        i2c_exec;
  logic        bit_ctrl;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;

  modport slave (
    input  req_a, rh_wl_a, addr_a, wdata_a,
    input  req_b, rh_wl_b, addr_b, wdata_b,
    output done_a, done_b, rdata, err, busy,
    output i2c_exec, bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w,
    input  i2c_data_r, i2c_done, i2c_ack
  );

  modport master (
    output req_a, rh_wl_a, addr_a, wdata_a,
    output req_b, rh_wl_b, addr_b, wdata_b,
    input  done_a, done_b, rdata, err, busy,
    input  i2c_exec, bit_ctrl, i2c_rh_wl, i2c_addr, i2c_data_w,
    output i2c_data_r, i2c_done, i2c_ack
  );

endinterface

// File: rtl/eeprom_req_arb_down_cnt.sv
// Loadable down-counter that stops at zero; used for write holdoff and retry gap.
module down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/eeprom_req_arb.sv
// Round-robin arbiter/sequencer for two EEPROM requesters sharing one i2c_dri,
// with NACK retry and post-write holdoff.
module eeprom_req_arb
  import eeprom_pkg::*;
#(
  parameter int   WR_CYCLE  = DEF_WR_CYCLE,
  parameter int   MAX_RETRY = DEF_MAX_RETRY,
  parameter int   RETRY_GAP = DEF_RETRY_GAP,
  parameter logic BIT_CTRL  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  eeprom_req_arb_if.slave bus
);

  localparam int HW = cnt_w(WR_CYCLE);
  localparam int GW = cnt_w(RETRY_GAP);
  localparam int RW = cnt_w(MAX_RETRY + 1);

  localparam logic [HW-1:0] HOLD_LOAD = HW'(WR_CYCLE - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(RETRY_GAP - 1);
  localparam logic [RW-1:0] MAX_R     = RW'(MAX_RETRY);

  state_t        state;
  state_t        next_state;
  logic          owner_b;
  logic          last_b;
  logic [RW-1:0] retry_cnt;
  logic          rh_wl_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_q;
  logic          err_q;

  logic hold_zero;
  logic gap_zero;
  logic hold_load;
  logic gap_load;
  logic grant;
  logic grant_b;
  logic nack;
  logic can_retry;
  logic exec;
  logic done_a;
  logic done_b;
  logic busy;

  assign grant     = hold_zero && (bus.req_a || bus.req_b);
  // Prefer B when A was served last or when only B is asking.
  assign grant_b   = bus.req_b && (!bus.req_a || !last_b);
  assign nack      = bus.i2c_done && bus.i2c_ack;
  assign can_retry = (retry_cnt < MAX_R);
  assign gap_load  = (state == ST_WAIT) && nack && can_retry;
  // err_q already reflects this transfer's outcome by the time RESP is reached.
  assign hold_load = (state == ST_RESP) && !err_q && !rh_wl_q;

  down_cnt #(.W(HW)) u_holdoff (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .zero     (hold_zero)
  );

  down_cnt #(.W(GW)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (grant) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (bus.i2c_done) begin
          next_state = (nack && can_retry) ? ST_GAP : ST_RESP;
        end
      end
      ST_GAP:   if (gap_zero) next_state = ST_ISSUE;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    exec   = 1'b0;
    done_a = 1'b0;
    done_b = 1'b0;
    busy   = (state != ST_IDLE) || !hold_zero;
    if (state == ST_ISSUE) exec = 1'b1;
    if (state == ST_RESP) begin
      done_a = !owner_b;
      done_b = owner_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_b   <= 1'b0;
      last_b    <= 1'b0;
      retry_cnt <= '0;
      rh_wl_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner_b   <= grant_b;
            rh_wl_q   <= grant_b ? bus.rh_wl_b : bus.rh_wl_a;
            addr_q    <= grant_b ? bus.addr_b : bus.addr_a;
            wdata_q   <= grant_b ? bus.wdata_b : bus.wdata_a;
            retry_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (bus.i2c_done) begin
            if (!bus.i2c_ack) begin
              if (rh_wl_q) rdata_q <= bus.i2c_data_r;
              err_q <= 1'b0;
            end else if (can_retry) begin
              retry_cnt <= retry_cnt + RW'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RESP: last_b <= owner_b;
        default: ;
      endcase
    end
  end

  assign bus.i2c_exec   = exec;
  assign bus.done_a     = done_a;
  assign bus.done_b     = done_b;
  assign bus.busy       = busy;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;
  assign bus.bit_ctrl   = BIT_CTRL;
  assign bus.i2c_rh_wl  = rh_wl_q;
  assign bus.i2c_addr   = addr_q;
  assign bus.i2c_data_w = wdata_q;

endmodule

// File: tb/tb_eeprom_req_arb.sv
// Directed bench for eeprom_req_arb with a behavioural i2c_dri/EEPROM model.
module tb_eeprom_req_arb;
  import eeprom_pkg::*;

  localparam int WR_CYCLE  = 10000;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_GAP = 1000;
  localparam int LAT       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eeprom_req_arb_if bus();

  eeprom_req_arb #(
    .WR_CYCLE  (WR_CYCLE),
    .MAX_RETRY (MAX_RETRY),
    .RETRY_GAP (RETRY_GAP),
    .BIT_CTRL  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural i2c_dri + EEPROM, evaluated on the falling edge.
  logic [7:0]  mem [int];
  int          exec_cnt      = 0;
  int          lat           = 0;
  int          last_done_cyc = 0;
  int          done_a_cnt    = 0;
  int          done_b_cnt    = 0;
  int          exec_cyc [$];
  logic        m_rh;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;
  logic        m_bc;
  int          nack_base  = 0;
  int          nack_first = 0;
  bit          always_nack = 1'b0;

  always @(negedge clk) begin
    if (bus.done_a) done_a_cnt++;
    if (bus.done_b) done_b_cnt++;
    bus.i2c_done = 1'b0;
    if (bus.i2c_exec) begin
      exec_cnt++;
      exec_cyc.push_back(cyc);
      m_rh   = bus.i2c_rh_wl;
      m_addr = bus.i2c_addr;
      m_wd   = bus.i2c_data_w;
      m_bc   = bus.bit_ctrl;
      lat    = LAT;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        bus.i2c_done  = 1'b1;
        last_done_cyc = cyc;
        if (always_nack || (exec_cnt - nack_base <= nack_first)) begin
          bus.i2c_ack = 1'b1;
        end else begin
          bus.i2c_ack = 1'b0;
          if (!m_rh) mem[int'(m_addr)] = m_wd;
          bus.i2c_data_r = mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : 8'h00;
        end
      end
    end
  end

  task automatic run_req(input bit side_b, input bit rh, input logic [15:0] addr,
                         input logic [7:0] wd, input int limit,
                         output bit got, output logic [7:0] rd, output bit e, output int dcyc);
    got = 1'b0; rd = 8'h00; e = 1'b0; dcyc = 0;
    if (side_b) begin
      bus.rh_wl_b = rh; bus.addr_b = addr; bus.wdata_b = wd; bus.req_b = 1'b1;
    end else begin
      bus.rh_wl_a = rh; bus.addr_a = addr; bus.wdata_a = wd; bus.req_a = 1'b1;
    end
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge clk);
      if (side_b ? bus.done_b : bus.done_a) begin
        got = 1'b1; rd = bus.rdata; e = bus.err; dcyc = cyc;
      end
    end
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_exec"},     bus.i2c_exec,   1'b0);
    check({tag, "_done_a"},   bus.done_a,     1'b0);
    check({tag, "_done_b"},   bus.done_b,     1'b0);
    check({tag, "_err"},      bus.err,        1'b0);
    check({tag, "_busy"},     bus.busy,       1'b0);
    check({tag, "_rh_wl"},    bus.i2c_rh_wl,  1'b0);
    check({tag, "_addr"},     bus.i2c_addr,   16'h0000);
    check({tag, "_data_w"},   bus.i2c_data_w, 8'h00);
    check({tag, "_rdata"},    bus.rdata,      8'h00);
    check({tag, "_bit_ctrl"}, bus.bit_ctrl,   1'b1);
  endtask

  typedef struct {
    bit          side_b;
    bit          rh;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit          got, got_a, got_b, e, drop_a, drop_b, seen;
    logic [7:0]  rd, rd_a, rd_b;
    int          dcyc, dcyc_a, e0, qi, da, db, first, c0, sp1, sp2;

    vecs[0] = '{1'b1, 1'b0, 16'hFFFF, 8'h5A, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 16'h0555, 8'h00, 8'hAA};
    vecs[3] = '{1'b0, 1'b0, 16'h8001, 8'h3C, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 16'h8001, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 1'b1, 16'h1234, 8'h00, 8'h00};

    bus.req_a = 1'b0; bus.rh_wl_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.rh_wl_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // A writes 0x0555 = 0xAA
    run_req(1'b0, 1'b0, 16'h0555, 8'hAA, 200, got, rd, e, dcyc_a);
    check("wr_done",     got, 1'b1);
    check("wr_err",      e, 1'b0);
    check("wr_execs",    exec_cnt, 1);
    check("wr_bit_ctrl", m_bc, 1'b1);
    check("wr_rh_wl",    m_rh, 1'b0);
    check("wr_addr",     m_addr, 16'h0555);
    check("wr_data",     m_wd, 8'hAA);
    check("wr_done_lat", dcyc_a - last_done_cyc, 1);
    check("hold_busy",   bus.busy, 1'b1);

    // B reads back, raised the cycle after done_a; must sit out the write cycle
    qi = exec_cyc.size();
    run_req(1'b1, 1'b1, 16'h0555, 8'h00, 20000, got, rd, e, dcyc);
    check("hold_done",  got, 1'b1);
    check("hold_rdata", rd, 8'hAA);
    check("hold_err",   e, 1'b0);
    check("hold_execs", exec_cnt, 2);
    check("hold_gap",   (exec_cyc.size() > qi) ? exec_cyc[qi] - dcyc_a : 0, WR_CYCLE + 1);

    // Make A the last grant, then raise both together
    run_req(1'b0, 1'b1, 16'h0555, 8'h00, 200, got, rd, e, dcyc);
    check("pre_rr_done", got, 1'b1);
    e0 = exec_cnt; da = done_a_cnt; db = done_b_cnt;
    first = -1; got_a = 1'b0; got_b = 1'b0; rd_a = 8'h00; rd_b = 8'h00;
    bus.rh_wl_a = 1'b1; bus.addr_a = 16'h0555;
    bus.rh_wl_b = 1'b1; bus.addr_b = 16'h1234;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int n = 0; n < 3000 && !(got_a && got_b); n++) begin
      @(negedge clk);
      drop_a = 1'b0; drop_b = 1'b0;
      if (bus.done_a) begin got_a = 1'b1; rd_a = bus.rdata; drop_a = 1'b1; if (first < 0) first = 0; end
      if (bus.done_b) begin got_b = 1'b1; rd_b = bus.rdata; drop_b = 1'b1; if (first < 0) first = 1; end
      @(posedge clk); #1;
      if (drop_a) bus.req_a = 1'b0;
      if (drop_b) bus.req_b = 1'b0;
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    repeat (20) @(negedge clk);
    check("rr_first_b", first, 1);
    check("rr_done_a",  done_a_cnt - da, 1);
    check("rr_done_b",  done_b_cnt - db, 1);
    check("rr_execs",   exec_cnt - e0, 2);
    check("rr_rdata_a", rd_a, 8'hAA);
    check("rr_rdata_b", rd_b, 8'h00);

    // Vector table of single transactions
    for (int i = 0; i < 6; i++) begin
      e0 = exec_cnt;
      run_req(vecs[i].side_b, vecs[i].rh, vecs[i].addr, vecs[i].wd, 20000, got, rd, e, dcyc);
      check($sformatf("vec%0d_done", i),  got, 1'b1);
      check($sformatf("vec%0d_err", i),   e, 1'b0);
      check($sformatf("vec%0d_execs", i), exec_cnt - e0, 1);
      check($sformatf("vec%0d_rh", i),    m_rh, vecs[i].rh);
      check($sformatf("vec%0d_addr", i),  m_addr, vecs[i].addr);
      if (vecs[i].rh) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      else            check($sformatf("vec%0d_wdata", i), m_wd, vecs[i].wd);
    end
    repeat (WR_CYCLE + 2) @(posedge clk);
    #1;

    // First two attempts NACKed, third succeeds
    e0 = exec_cnt; qi = exec_cyc.size();
    nack_base = exec_cnt; nack_first = 2;
    run_req(1'b0, 1'b1, 16'h0555, 8'h00, 20000, got, rd, e, dcyc);
    nack_first = 0;
    sp1 = (exec_cyc.size() >= qi + 3) ? exec_cyc[qi+1] - exec_cyc[qi] : 0;
    sp2 = (exec_cyc.size() >= qi + 3) ? exec_cyc[qi+2] - exec_cyc[qi+1] : 0;
    check("nack2_done",  got, 1'b1);
    check("nack2_err",   e, 1'b0);
    check("nack2_rdata", rd, 8'hAA);
    check("nack2_execs", exec_cnt - e0, 3);
    check("nack2_gap1",  sp1, RETRY_GAP + LAT + 1);
    check("nack2_gap2",  sp2, RETRY_GAP + LAT + 1);

    // Every attempt NACKed
    e0 = exec_cnt; always_nack = 1'b1;
    run_req(1'b1, 1'b1, 16'h0555, 8'h00, 20000, got, rd, e, dcyc);
    always_nack = 1'b0;
    check("nackall_done",  got, 1'b1);
    check("nackall_err",   e, 1'b1);
    check("nackall_execs", exec_cnt - e0, MAX_RETRY + 1);
    e0 = exec_cnt;
    run_req(1'b0, 1'b1, 16'h0555, 8'h00, 200, got, rd, e, dcyc);
    check("after_nack_done",  got, 1'b1);
    check("after_nack_err",   e, 1'b0);
    check("after_nack_rdata", rd, 8'hAA);
    check("after_nack_execs", exec_cnt - e0, 1);

    // Reset while waiting on i2c_dri; its done then lands in IDLE
    seen = 1'b0;
    bus.rh_wl_a = 1'b1; bus.addr_a = 16'h0555; bus.req_a = 1'b1;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (bus.i2c_exec) seen = 1'b1;
    end
    check("rst_exec_seen", seen, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; bus.req_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    da = done_a_cnt; db = done_b_cnt;
    @(negedge clk);
    check_reset_values("rst_mid");
    e0 = exec_cnt;
    repeat (10) @(negedge clk);
    check("rst_no_done_a", done_a_cnt - da, 0);
    check("rst_no_done_b", done_b_cnt - db, 0);
    check("rst_no_exec",   exec_cnt - e0, 0);
    check("rst_idle_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    c0 = cyc; qi = exec_cyc.size();
    run_req(1'b1, 1'b1, 16'h1234, 8'h00, 200, got, rd, e, dcyc);
    check("rst_new_issue", (exec_cyc.size() > qi) ? exec_cyc[qi] - c0 : 0, 1);
    check("rst_new_done",  got, 1'b1);
    check("rst_new_rdata", rd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
